// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: 2-bit counter encoding and
// the saturating update rule used by every BHT entry.
package bp_pkg;

    localparam logic [1:0] SNT       = 2'b00;
    localparam logic [1:0] WNT       = 2'b01;
    localparam logic [1:0] WT        = 2'b10;
    localparam logic [1:0] ST        = 2'b11;
    localparam logic [1:0] BHT_RESET = WNT;

    function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
        if (taken) begin
            return (cnt == ST) ? ST : cnt + 2'd1;
        end
        return (cnt == SNT) ? SNT : cnt - 2'd1;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// IF/ID-stage signal bundle between the pipeline (master) and the predictor (slave).
interface branch_predictor_if #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
);
    logic [WIDTH-1:0]     IF_pc;
    logic                 IF_Branch;
    logic                 IF_prediction;
    logic                 ID_stall;
    logic                 ID_flush;
    logic [WIDTH-1:0]     ID_pc;
    logic                 ID_Branch;
    logic                 ID_correction;
    logic                 ID_prediction;
    logic                 ID_mispredict;
    logic [CNT_WIDTH-1:0] branch_count;
    logic [CNT_WIDTH-1:0] mispredict_count;

    modport master (
        output IF_pc, IF_Branch, ID_stall, ID_flush, ID_pc, ID_Branch, ID_correction,
        input  IF_prediction, ID_prediction, ID_mispredict, branch_count, mispredict_count
    );

    modport slave (
        input  IF_pc, IF_Branch, ID_stall, ID_flush, ID_pc, ID_Branch, ID_correction,
        output IF_prediction, ID_prediction, ID_mispredict, branch_count, mispredict_count
    );
endinterface

// File: rtl/branch_predictor_sat_counter2.sv
// One BHT entry: a 2-bit saturating counter that resets to weak not-taken.
module sat_counter2
    import bp_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic taken,
    output logic pred
);
    logic [1:0] cnt_q;
    logic [1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = sat_update(cnt_q, taken);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= BHT_RESET;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign pred = cnt_q[1];
endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped 2-bit BHT predictor: IF-stage lookup, ID-stage prediction
// register, resolved-outcome update and saturating performance counters.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int IDX_BITS  = 6,
    parameter int CNT_WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    branch_predictor_if.slave  bus
);
    localparam int ENTRIES = 1 << IDX_BITS;

    logic [IDX_BITS-1:0]  if_idx;
    logic [IDX_BITS-1:0]  id_idx;
    logic [ENTRIES-1:0]   pred_vec;
    logic                 upd;
    logic                 if_pred;
    logic                 mispredict;

    logic                 id_pred_q;
    logic                 id_pred_d;
    logic [CNT_WIDTH-1:0] branch_count_q;
    logic [CNT_WIDTH-1:0] branch_count_d;
    logic [CNT_WIDTH-1:0] mispredict_count_q;
    logic [CNT_WIDTH-1:0] mispredict_count_d;

    assign if_idx = bus.IF_pc[IDX_BITS+1:2];
    assign id_idx = bus.ID_pc[IDX_BITS+1:2];

    // Upper PC bits and the byte offset are deliberately ignored (aliasing is allowed).
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.IF_pc, bus.ID_pc};

    // A flush still resolves the ID branch; only a stall defers it.
    assign upd = bus.ID_Branch & ~bus.ID_stall;

    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_bht
        sat_counter2 u_cnt (
            .clk   (clk),
            .rst   (rst),
            .en    (upd && (id_idx == IDX_BITS'(gi))),
            .taken (bus.ID_correction),
            .pred  (pred_vec[gi])
        );
    end

    assign if_pred    = bus.IF_Branch & pred_vec[if_idx];
    assign mispredict = bus.ID_Branch & (id_pred_q != bus.ID_correction);

    always_comb begin
        id_pred_d          = id_pred_q;
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;

        if (bus.ID_flush) begin
            id_pred_d = 1'b0;
        end else if (!bus.ID_stall) begin
            id_pred_d = if_pred;
        end

        if (upd && (branch_count_q != '1)) begin
            branch_count_d = branch_count_q + 1'b1;
        end
        if (upd && mispredict && (mispredict_count_q != '1)) begin
            mispredict_count_d = mispredict_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_pred_q          <= 1'b0;
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            id_pred_q          <= id_pred_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign bus.IF_prediction    = if_pred;
    assign bus.ID_prediction    = id_pred_q;
    assign bus.ID_mispredict    = mispredict;
    assign bus.branch_count     = branch_count_q;
    assign bus.mispredict_count = mispredict_count_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed IF/ID vectors, a table-of-ints reference
// model checked every cycle, and hand-computed expectations at key points.
module tb_branch_predictor;
    localparam int W   = 32;
    localparam int IDX = 6;
    localparam int CW  = 4;
    localparam int ENT = 64;
    localparam int CMAX = 15;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   cyc;

    branch_predictor_if #(.WIDTH(W), .CNT_WIDTH(CW)) bp_bus ();

    branch_predictor #(.WIDTH(W), .IDX_BITS(IDX), .CNT_WIDTH(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bp_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: counters as plain integers 0..3, taken when >= 2.
    int m_bht [ENT];
    int m_id_pred;
    int m_bc;
    int m_mc;
    bit model_valid = 1'b0;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % ENT);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(posedge clk) begin
        int mif;
        int mis;
        int k;
        if (rst) begin
            for (int i = 0; i < ENT; i++) m_bht[i] = 1;
            m_id_pred   = 0;
            m_bc        = 0;
            m_mc        = 0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            mif = (bp_bus.IF_Branch && m_bht[idx_of(bp_bus.IF_pc)] >= 2) ? 1 : 0;
            mis = (bp_bus.ID_Branch && (m_id_pred != int'(bp_bus.ID_correction))) ? 1 : 0;
            if (bp_bus.ID_Branch && !bp_bus.ID_stall) begin
                k = idx_of(bp_bus.ID_pc);
                if (bp_bus.ID_correction) m_bht[k] = (m_bht[k] == 3) ? 3 : m_bht[k] + 1;
                else                      m_bht[k] = (m_bht[k] == 0) ? 0 : m_bht[k] - 1;
                m_bc = (m_bc == CMAX) ? CMAX : m_bc + 1;
                if (mis == 1) m_mc = (m_mc == CMAX) ? CMAX : m_mc + 1;
            end
            if (bp_bus.ID_flush)      m_id_pred = 0;
            else if (!bp_bus.ID_stall) m_id_pred = mif;
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            chk("model_if_pred", 32'(bp_bus.IF_prediction),
                (bp_bus.IF_Branch && m_bht[idx_of(bp_bus.IF_pc)] >= 2) ? 32'd1 : 32'd0);
            chk("model_id_pred", 32'(bp_bus.ID_prediction), 32'(m_id_pred));
            chk("model_mispredict", 32'(bp_bus.ID_mispredict),
                (bp_bus.ID_Branch && (m_id_pred != int'(bp_bus.ID_correction))) ? 32'd1 : 32'd0);
            chk("model_branch_count", 32'(bp_bus.branch_count), 32'(m_bc));
            chk("model_mispredict_count", 32'(bp_bus.mispredict_count), 32'(m_mc));
        end
    end

    task automatic drv(input logic r, input logic ifb, input logic [31:0] ifpc,
                       input logic st, input logic fl, input logic idb,
                       input logic [31:0] idpc, input logic corr);
        @(posedge clk);
        #1;
        rst                  = r;
        bp_bus.IF_Branch     = ifb;
        bp_bus.IF_pc         = ifpc;
        bp_bus.ID_stall      = st;
        bp_bus.ID_flush      = fl;
        bp_bus.ID_Branch     = idb;
        bp_bus.ID_pc         = idpc;
        bp_bus.ID_correction = corr;
        cyc++;
        $display("cyc %0d rst=%0b IF(br=%0b pc=%0h) ID(br=%0b pc=%0h taken=%0b stall=%0b flush=%0b)",
                 cyc, r, ifb, ifpc, idb, idpc, corr, st, fl);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        rst    = 1'b1;
        bp_bus.IF_Branch = 1'b0; bp_bus.IF_pc = '0;
        bp_bus.ID_stall  = 1'b0; bp_bus.ID_flush = 1'b0;
        bp_bus.ID_Branch = 1'b0; bp_bus.ID_pc = '0; bp_bus.ID_correction = 1'b0;

        drv(1, 0, 0, 0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0, 0, 0);

        // Reset state: entry 01 predicts not-taken.
        drv(0, 1, 32'h100, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("reset_if_pred", 32'(bp_bus.IF_prediction), 0);
        chk("reset_id_pred", 32'(bp_bus.ID_prediction), 0);
        chk("reset_branch_count", 32'(bp_bus.branch_count), 0);
        chk("reset_mispredict", 32'(bp_bus.ID_mispredict), 0);

        // Same-cycle update and lookup: old value used this cycle.
        drv(0, 1, 32'h100, 0, 0, 1, 32'h100, 1);
        @(negedge clk);
        chk("same_cycle_if_pred", 32'(bp_bus.IF_prediction), 0);
        chk("first_mispredict", 32'(bp_bus.ID_mispredict), 1);
        drv(0, 1, 32'h100, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("next_cycle_if_pred", 32'(bp_bus.IF_prediction), 1);
        chk("mcount_after_first", 32'(bp_bus.mispredict_count), 1);

        // Three more taken resolutions saturate the entry at 11.
        drv(0, 1, 32'h100, 0, 0, 1, 32'h100, 1);
        drv(0, 1, 32'h100, 0, 0, 1, 32'h100, 1);
        drv(0, 0, 0,       0, 0, 1, 32'h100, 1);

        // Aliasing: 0x200 shares index 0, 0x104 is index 1.
        drv(0, 1, 32'h200, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("alias_0x200", 32'(bp_bus.IF_prediction), 1);
        drv(0, 1, 32'h104, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("index1_0x104", 32'(bp_bus.IF_prediction), 0);
        chk("bcount_4", 32'(bp_bus.branch_count), 4);

        // Load ID_prediction = 1, then resolve not-taken.
        drv(0, 1, 32'h100, 0, 0, 0, 0, 0);
        drv(0, 0, 0,       0, 0, 1, 32'h100, 0);
        @(negedge clk);
        chk("nt_mispredict", 32'(bp_bus.ID_mispredict), 1);
        drv(0, 1, 32'h100, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("after_nt_if_pred", 32'(bp_bus.IF_prediction), 1);
        chk("mcount_2", 32'(bp_bus.mispredict_count), 2);
        chk("bcount_5", 32'(bp_bus.branch_count), 5);

        // Stall three cycles with a pending branch: nothing moves.
        for (int i = 0; i < 3; i++) begin
            drv(0, 1, 32'h104, 1, 0, 1, 32'h100, 0);
            @(negedge clk);
            chk("stall_id_pred_hold", 32'(bp_bus.ID_prediction), 1);
        end
        // Flush cycle still resolves the ID branch (0x104 taken).
        drv(0, 1, 32'h100, 0, 1, 1, 32'h104, 1);
        @(negedge clk);
        chk("stall_bcount_frozen", 32'(bp_bus.branch_count), 5);
        chk("stall_table_frozen", 32'(bp_bus.IF_prediction), 1);
        drv(0, 1, 32'h104, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("flush_clears_id_pred", 32'(bp_bus.ID_prediction), 0);
        chk("flush_still_updates", 32'(bp_bus.IF_prediction), 1);
        chk("bcount_6", 32'(bp_bus.branch_count), 6);

        // Twenty branches saturate the 4-bit branch counter.
        for (int i = 0; i < 20; i++) begin
            drv(0, 1, 32'(i * 4), 0, 0, 1, 32'(i * 8), 1'(i % 2));
        end
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("bcount_saturated", 32'(bp_bus.branch_count), 15);

        // Mid-operation reset with a live ID branch: no update, table reinitialised.
        drv(1, 0, 0, 0, 0, 1, 32'h100, 1);
        drv(0, 1, 32'h100, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("rst2_if_pred", 32'(bp_bus.IF_prediction), 0);
        chk("rst2_branch_count", 32'(bp_bus.branch_count), 0);
        chk("rst2_mispredict_count", 32'(bp_bus.mispredict_count), 0);
        chk("rst2_id_pred", 32'(bp_bus.ID_prediction), 0);
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
